crb_transfer: RTL and testbench

- Command/Response Buffer (CRB) stage directly downstream of the FRS FIFO buffer.
- On FIFO request: copies the command bytes out of the FIFO into a local RAM, then hands the command to the execution engine.
- Execution engine reads the command from the local RAM and writes the response back into it.
- After execution: streams the response back into the FIFO, owning the FIFO address and write strobe for both transfers.

---
 rtl/crb_transfer.sv | 216 +++++++++++++++++++++
 tb/tb_crb_transfer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crb_transfer.sv
// rtl/crb_transfer.sv - Command/response buffer transfer stage behind the FRS FIFO
//
// Copies a command out of the FIFO into a local byte RAM, hands the RAM to the
// execution engine, then streams the response back into the FIFO.
//
// Ports:
//   clock, reset              rising-edge clock, asynchronous active-high reset
//   f_abort                   synchronous return to Idle from any state
//   c_cmdSize, c_cmdSend      command length and start pulse from the FIFO
//   cmdByteOut, c_cmdInAddr   FIFO read data (1-cycle latency) and read address
//   c_cmdDone, exec_start     coincident pulses when the command is in local RAM
//   e_execDone                exec engine finished, response is in local RAM
//   exec_addr/wren/wdata      exec engine access into local RAM
//   exec_rdata                local RAM read data, 1-cycle latency
//   c_rspSize                 response length captured from header bytes 2..5
//   c_rspSend, c_rspInAddr    FIFO write strobe (active low) and write address
//   rspByteIn, c_rspDone      response byte to FIFO, end-of-response pulse
//   size_err                  sticky: last command/response size out of range
module crb_transfer #(
    parameter int BUF_SIZE = 4096,
    parameter int AW       = 12
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          f_abort,
    input  logic [31:0]   c_cmdSize,
    input  logic          c_cmdSend,
    input  logic [7:0]    cmdByteOut,
    output logic [AW-1:0] c_cmdInAddr,
    output logic          c_cmdDone,
    output logic          exec_start,
    input  logic          e_execDone,
    input  logic [AW-1:0] exec_addr,
    input  logic          exec_wren,
    input  logic [7:0]    exec_wdata,
    output logic [7:0]    exec_rdata,
    output logic [31:0]   c_rspSize,
    output logic          c_rspSend,
    output logic [AW-1:0] c_rspInAddr,
    output logic [7:0]    rspByteIn,
    output logic          c_rspDone,
    output logic          size_err
);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_CMD_LOAD   = 3'd1;
    localparam logic [2:0] ST_CMD_DONE   = 3'd2;
    localparam logic [2:0] ST_EXEC_BUSY  = 3'd3;
    localparam logic [2:0] ST_RSP_DELAY  = 3'd4;
    localparam logic [2:0] ST_RSP_STREAM = 3'd5;
    localparam logic [2:0] ST_RSP_DONE   = 3'd6;

    logic [2:0]    state;
    logic [AW-1:0] lastAddr;     // final transfer address, N-1 or M-1
    logic          rspZero;      // response length was zero
    logic          delayPhase;   // second RspDelay cycle
    logic          loadValid;    // FIFO byte on cmdByteOut belongs in RAM
    logic [AW-1:0] loadAddr;     // RAM address for that byte

    logic [7:0]    mem [BUF_SIZE];
    logic [7:0]    ramQ;
    logic          ramEn;
    logic          ramWe;
    logic [AW-1:0] ramAddr;
    logic [7:0]    ramWdata;

    function automatic logic sizeBad(input logic [31:0] size);
        return (size == 32'd0) || (size > 32'(BUF_SIZE));
    endfunction

    function automatic logic [AW-1:0] sizeLast(input logic [31:0] size);
        return (size > 32'(BUF_SIZE)) ? AW'(BUF_SIZE - 1) : AW'(size - 32'd1);
    endfunction

    // The FIFO byte for the final command address arrives one cycle after the
    // address, which is the CmdDone cycle, so the load pipeline takes the port
    // whenever it holds a byte rather than only while in CmdLoad.
    always_comb begin
        ramEn    = 1'b0;
        ramWe    = 1'b0;
        ramAddr  = '0;
        ramWdata = '0;
        if (loadValid) begin
            ramEn    = 1'b1;
            ramWe    = 1'b1;
            ramAddr  = loadAddr;
            ramWdata = cmdByteOut;
        end else begin
            case (state)
                ST_EXEC_BUSY: begin
                    ramEn    = 1'b1;
                    ramWe    = exec_wren;
                    ramAddr  = exec_addr;
                    ramWdata = exec_wdata;
                end
                ST_RSP_DELAY: begin
                    ramEn = delayPhase;
                end
                ST_RSP_STREAM: begin
                    // Read one address ahead so bytes leave back to back.
                    ramEn   = 1'b1;
                    ramAddr = c_rspInAddr + AW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (ramEn && ramWe) begin
            mem[ramAddr] <= ramWdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ramQ <= '0;
        end else if (ramEn) begin
            ramQ <= mem[ramAddr];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            c_cmdInAddr <= '0;
            c_rspInAddr <= '0;
            lastAddr    <= '0;
            rspZero     <= 1'b0;
            delayPhase  <= 1'b0;
            loadValid   <= 1'b0;
            loadAddr    <= '0;
            c_rspSize   <= '0;
            size_err    <= 1'b0;
        end else begin
            loadValid <= (state == ST_CMD_LOAD) && !f_abort;
            loadAddr  <= c_cmdInAddr;

            if (state == ST_EXEC_BUSY && exec_wren) begin
                case (exec_addr)
                    AW'(2):  c_rspSize[31:24] <= exec_wdata;
                    AW'(3):  c_rspSize[23:16] <= exec_wdata;
                    AW'(4):  c_rspSize[15:8]  <= exec_wdata;
                    AW'(5):  c_rspSize[7:0]   <= exec_wdata;
                    default: ;
                endcase
            end

            if (f_abort) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (c_cmdSend) begin
                            size_err    <= sizeBad(c_cmdSize);
                            lastAddr    <= sizeLast(c_cmdSize);
                            c_cmdInAddr <= '0;
                            state       <= (c_cmdSize == 32'd0) ? ST_CMD_DONE : ST_CMD_LOAD;
                        end
                    end
                    ST_CMD_LOAD: begin
                        if (c_cmdInAddr == lastAddr) begin
                            state <= ST_CMD_DONE;
                        end else begin
                            c_cmdInAddr <= c_cmdInAddr + AW'(1);
                        end
                    end
                    ST_CMD_DONE: begin
                        state <= ST_EXEC_BUSY;
                    end
                    ST_EXEC_BUSY: begin
                        if (e_execDone) begin
                            if (sizeBad(c_rspSize)) begin
                                size_err <= 1'b1;
                            end
                            lastAddr   <= sizeLast(c_rspSize);
                            rspZero    <= (c_rspSize == 32'd0);
                            delayPhase <= 1'b0;
                            state      <= ST_RSP_DELAY;
                        end
                    end
                    ST_RSP_DELAY: begin
                        if (!delayPhase) begin
                            delayPhase <= 1'b1;
                        end else begin
                            c_rspInAddr <= '0;
                            state       <= rspZero ? ST_RSP_DONE : ST_RSP_STREAM;
                        end
                    end
                    ST_RSP_STREAM: begin
                        if (c_rspInAddr == lastAddr) begin
                            state <= ST_RSP_DONE;
                        end else begin
                            c_rspInAddr <= c_rspInAddr + AW'(1);
                        end
                    end
                    ST_RSP_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // An abort suppresses done pulses and the FIFO write in the abort cycle.
    assign c_cmdDone  = (state == ST_CMD_DONE) && !f_abort;
    assign exec_start = c_cmdDone;
    assign c_rspDone  = (state == ST_RSP_DONE) && !f_abort;
    assign c_rspSend  = !((state == ST_RSP_STREAM) && !f_abort);
    assign rspByteIn  = (state == ST_RSP_STREAM) ? ramQ : 8'h00;
    assign exec_rdata = ramQ;

endmodule

// File: tb/tb_crb_transfer.sv
// tb/tb_crb_transfer.sv - Directed self-checking bench for crb_transfer
module tb_crb_transfer;

    localparam int AW = 12;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          f_abort;
    logic [31:0]   c_cmdSize;
    logic          c_cmdSend;
    logic [7:0]    cmdByteOut = 8'h00;
    logic [AW-1:0] c_cmdInAddr;
    logic          c_cmdDone;
    logic          exec_start;
    logic          e_execDone;
    logic [AW-1:0] exec_addr;
    logic          exec_wren;
    logic [7:0]    exec_wdata;
    logic [7:0]    exec_rdata;
    logic [31:0]   c_rspSize;
    logic          c_rspSend;
    logic [AW-1:0] c_rspInAddr;
    logic [7:0]    rspByteIn;
    logic          c_rspDone;
    logic          size_err;

    int checks = 0;
    int passes = 0;
    int errs;
    int cnt;
    logic [AW-1:0] lastSeen;

    crb_transfer #(.BUF_SIZE(4096), .AW(AW)) dut (
        .clock       (clock),
        .reset       (reset),
        .f_abort     (f_abort),
        .c_cmdSize   (c_cmdSize),
        .c_cmdSend   (c_cmdSend),
        .cmdByteOut  (cmdByteOut),
        .c_cmdInAddr (c_cmdInAddr),
        .c_cmdDone   (c_cmdDone),
        .exec_start  (exec_start),
        .e_execDone  (e_execDone),
        .exec_addr   (exec_addr),
        .exec_wren   (exec_wren),
        .exec_wdata  (exec_wdata),
        .exec_rdata  (exec_rdata),
        .c_rspSize   (c_rspSize),
        .c_rspSend   (c_rspSend),
        .c_rspInAddr (c_rspInAddr),
        .rspByteIn   (rspByteIn),
        .c_rspDone   (c_rspDone),
        .size_err    (size_err)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] fifoByte(input int i);
        case (i)
            0:       return 8'h80;
            1:       return 8'h01;
            2, 3, 4: return 8'h00;
            5:       return 8'h0C;
            default: return 8'((i * 7 + 3) & 255);
        endcase
    endfunction

    function automatic logic [7:0] rspByte(input int i);
        case (i)
            0:          return 8'hA5;
            1:          return 8'h3C;
            2, 3, 4:    return 8'h00;
            5:          return 8'h0A;
            default:    return 8'(8'hD0 + i);
        endcase
    endfunction

    // FIFO model: synchronous read, one cycle latency.
    always @(posedge clock) cmdByteOut <= fifoByte(int'(c_cmdInAddr));

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Leaves the bench in cycle S+1.
    task automatic sendCmd(input logic [31:0] size);
        c_cmdSize = size;
        c_cmdSend = 1'b1;
        step();
        c_cmdSend = 1'b0;
    endtask

    task automatic checkResetVals(input string tag);
        checkVal({tag, "_rspSend"},   c_rspSend, 1);
        checkVal({tag, "_pulses"},    {c_cmdDone, exec_start, c_rspDone}, 0);
        checkVal({tag, "_addrs"},     {c_cmdInAddr, c_rspInAddr}, 0);
        checkVal({tag, "_bytes"},     {rspByteIn, exec_rdata}, 0);
        checkVal({tag, "_rspSize"},   c_rspSize, 0);
        checkVal({tag, "_size_err"},  size_err, 0);
    endtask

    initial begin
        f_abort = 0; c_cmdSize = 0; c_cmdSend = 0; e_execDone = 0;
        exec_addr = '0; exec_wren = 0; exec_wdata = 0;
        step(); step();
        @(negedge clock);
        checkResetVals("rst");
        step();
        reset = 1'b0;
        step();

        // Command copy, 12 bytes
        sendCmd(12);
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            checkVal($sformatf("cmd_addr[%0d]", k), c_cmdInAddr, k);
            checkVal($sformatf("cmd_done_early[%0d]", k), {c_cmdDone, exec_start}, 0);
            step();
        end
        @(negedge clock);
        checkVal("cmd_done", {c_cmdDone, exec_start}, 2'b11);
        checkVal("size_err_12", size_err, 0);
        step();
        for (int k = 0; k < 12; k++) begin
            exec_addr = AW'(k);
            step();
            @(negedge clock);
            checkVal($sformatf("ram_cmd[%0d]", k), exec_rdata, fifoByte(k));
        end

        // Response stream, 10 bytes
        exec_wren = 1'b1;
        for (int k = 0; k < 10; k++) begin
            exec_addr  = AW'(k);
            exec_wdata = rspByte(k);
            step();
        end
        exec_wren  = 1'b0;
        e_execDone = 1'b1;
        @(negedge clock);
        checkVal("rsp_size", c_rspSize, 10);
        step();
        e_execDone = 1'b0;
        @(negedge clock);
        checkVal("rsp_delay1", c_rspSend, 1);
        step();
        @(negedge clock);
        checkVal("rsp_delay2", c_rspSend, 1);
        step();
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            checkVal($sformatf("rsp_send[%0d]", k), {c_rspSend, c_rspDone}, 0);
            checkVal($sformatf("rsp_addr[%0d]", k), c_rspInAddr, k);
            checkVal($sformatf("rsp_byte[%0d]", k), rspByteIn, rspByte(k));
            step();
        end
        @(negedge clock);
        checkVal("rsp_done", {c_rspDone, c_rspSend}, 2'b11);
        step();
        @(negedge clock);
        checkVal("rsp_done_once", c_rspDone, 0);

        // Zero-length command
        step();
        sendCmd(0);
        @(negedge clock);
        checkVal("zero_cmd_done", c_cmdDone, 1);
        checkVal("zero_size_err", size_err, 1);
        step();
        f_abort = 1'b1;
        step();
        f_abort = 1'b0;
        @(negedge clock);
        checkVal("zero_abort_err_kept", size_err, 1);

        // Oversized command clamps to 4096 bytes
        step();
        sendCmd(5000);
        errs = 0; cnt = 0; lastSeen = '0;
        for (int k = 0; k < 4096; k++) begin
            @(negedge clock);
            if (c_cmdInAddr !== AW'(k)) errs++;
            if (c_cmdDone) cnt++;
            if (k == 4095) lastSeen = c_cmdInAddr;
            step();
        end
        checkVal("big_addr_seq_errs", errs, 0);
        checkVal("big_done_early", cnt, 0);
        checkVal("big_last_addr", lastSeen, 4095);
        @(negedge clock);
        checkVal("big_cmd_done", c_cmdDone, 1);
        checkVal("big_size_err", size_err, 1);
        step();
        exec_addr = AW'(4095);
        step();
        @(negedge clock);
        checkVal("big_ram_last", exec_rdata, fifoByte(4095));
        exec_addr = AW'(100);
        step();
        @(negedge clock);
        checkVal("big_ram_100", exec_rdata, fifoByte(100));
        f_abort = 1'b1;
        step();
        f_abort = 1'b0;

        // Abort mid-CmdLoad
        sendCmd(12);
        step(); step(); step();
        f_abort = 1'b1;
        @(negedge clock);
        checkVal("abort_cmd_done", c_cmdDone, 0);
        step();
        f_abort = 1'b0;
        @(negedge clock);
        checkVal("abort_size_err_cleared", size_err, 0);
        cnt = 0;
        repeat (12) begin
            @(negedge clock);
            if (c_cmdDone) cnt++;
            step();
        end
        checkVal("abort_no_cmd_done", cnt, 0);

        // Normal command after abort, then abort mid-RspStream
        sendCmd(12);
        repeat (12) step();
        @(negedge clock);
        checkVal("cmd_after_abort_done", c_cmdDone, 1);
        step();
        exec_wren = 1'b1; exec_addr = AW'(5); exec_wdata = 8'h08;
        step();
        exec_wren  = 1'b0;
        e_execDone = 1'b1;
        @(negedge clock);
        checkVal("rsp2_size", c_rspSize, 8);
        step();
        e_execDone = 1'b0;
        step(); step();
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            checkVal($sformatf("rsp2_addr[%0d]", k), c_rspInAddr, k);
            checkVal($sformatf("rsp2_byte[%0d]", k), {c_rspSend, rspByteIn}, {1'b0, fifoByte(k)});
            step();
        end
        f_abort = 1'b1;
        @(negedge clock);
        checkVal("abort_rsp_send_high", c_rspSend, 1);
        step();
        f_abort = 1'b0;
        cnt = 0;
        repeat (12) begin
            @(negedge clock);
            if (c_rspDone || !c_rspSend) cnt++;
            step();
        end
        checkVal("abort_rsp_quiet", cnt, 0);

        // Stray e_execDone and exec_wren in Idle
        e_execDone = 1'b1; exec_wren = 1'b1; exec_addr = AW'(5); exec_wdata = 8'hEE;
        step();
        e_execDone = 1'b0; exec_wren = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clock);
            if (c_rspDone || !c_rspSend) cnt++;
            step();
        end
        checkVal("stray_no_state_change", cnt, 0);
        checkVal("stray_rsp_size_kept", c_rspSize, 8);
        sendCmd(0);
        step();
        exec_addr = AW'(5);
        step();
        @(negedge clock);
        checkVal("stray_no_ram_write", exec_rdata, 8'h08);
        exec_addr = AW'(0);
        step();
        @(negedge clock);
        checkVal("ram_retained_after_abort", exec_rdata, 8'h80);

        // Asynchronous reset during RspStream
        exec_wren = 1'b1; exec_addr = AW'(5); exec_wdata = 8'h06;
        step();
        exec_wren  = 1'b0;
        e_execDone = 1'b1;
        step();
        e_execDone = 1'b0;
        step(); step(); step();
        #1;
        checkVal("pre_reset_stream", {c_rspSend, c_rspInAddr, rspByteIn}, {1'b0, 12'd1, 8'h01});
        reset = 1'b1;
        #1;
        checkResetVals("async_rst");
        step();
        reset = 1'b0;
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
